// File: rtl/psum_pkg.sv
// Shared types, default widths and the saturating narrowing helper for the
// column-bottom partial-sum accumulator.
package psum_pkg;

  localparam int unsigned DefW         = 16;
  localparam int unsigned DefLenW      = 8;
  localparam int unsigned DefCntW      = 8;
  localparam int unsigned DefFifoDepth = 4;

  // Widest accumulator the clamp helper accepts (W + LEN_W must stay below this).
  localparam int unsigned SatMaxW = 64;

  typedef enum logic [0:0] {
    StIdle,
    StAccum
  } state_e;

  typedef struct packed {
    logic                      ovf;
    logic signed [SatMaxW-1:0] val;
  } sat_t;

  // Clamp a sign-extended value into the signed range of a w-bit word.
  function automatic sat_t sat_w(input logic signed [SatMaxW-1:0] val, input int unsigned w);
    sat_t                      r;
    logic signed [SatMaxW-1:0] hi;
    logic signed [SatMaxW-1:0] lo;
    hi    = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo    = -(64'sd1 <<< (w - 1));
    r.ovf = 1'b0;
    r.val = val;
    if (val > hi) begin
      r.ovf = 1'b1;
      r.val = hi;
    end else if (val < lo) begin
      r.ovf = 1'b1;
      r.val = lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/psum_fifo.sv
// Small synchronous result FIFO with registered full/empty flags; the head
// word reads as zero while the FIFO is empty.
module psum_fifo #(
  parameter int unsigned W     = 16,
  parameter int unsigned Depth = 4
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [W-1:0]  mem_q [Depth];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic [AW:0]   cnt_d;
  logic          full_q;
  logic          empty_q;
  logic          push_ok;
  logic          pop_ok;

  assign push_ok = push && !full_q;
  assign pop_ok  = pop && !empty_q;

  always_comb begin
    cnt_d = cnt_q;
    if (push_ok && !pop_ok) begin
      cnt_d = cnt_q + (AW + 1)'(1);
    end else if (!push_ok && pop_ok) begin
      cnt_d = cnt_q - (AW + 1)'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == (AW + 1)'(Depth));
      empty_q <= (cnt_d == '0);
    end
  end

  // Storage needs no reset: the head is masked while empty.
  always_ff @(posedge CLK) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign pop_data = empty_q ? '0 : mem_q[rd_ptr_q];
  assign full     = full_q;
  assign empty    = empty_q;

endmodule

// File: rtl/psum_accumulator.sv
// Sums cfg_len consecutive column partial sums per output neuron, saturates
// each result to W bits and queues it toward the output-neuron buffer.
module psum_accumulator
  import psum_pkg::*;
#(
  parameter int unsigned W          = DefW,
  parameter int unsigned LEN_W      = DefLenW,
  parameter int unsigned CNT_W      = DefCntW,
  parameter int unsigned FIFO_DEPTH = DefFifoDepth
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             start,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [CNT_W-1:0] cfg_count,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     psum_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic             busy,
  output logic             done,
  output logic             sat_flag
);

  localparam int unsigned AccW = W + LEN_W;

  state_e                  state_q, state_d;
  logic [LEN_W-1:0]        len_q, len_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic signed [AccW-1:0]  acc_q, acc_d;
  logic [LEN_W-1:0]        samp_q, samp_d;
  logic [CNT_W-1:0]        neur_q, neur_d;
  logic                    sat_q, sat_d;
  logic                    done_q, done_d;

  logic                    beat;
  logic                    push;
  logic signed [AccW-1:0]  sum;
  sat_t                    sat_res;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    unused_sat_hi;

  assign in_ready = (state_q == StAccum) && !fifo_full;
  assign beat     = in_valid && in_ready;
  assign sum      = acc_q + {{LEN_W{psum_in[W-1]}}, psum_in};
  assign sat_res  = sat_w({{(SatMaxW - AccW){sum[AccW-1]}}, sum}, W);

  // Only the low W bits of the clamped value are meaningful.
  assign unused_sat_hi = ^sat_res.val[SatMaxW-1:W];

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    count_d = count_q;
    acc_d   = acc_q;
    samp_d  = samp_q;
    neur_d  = neur_q;
    sat_d   = sat_q;
    done_d  = 1'b0;
    push    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if ((cfg_len != '0) && (cfg_count != '0)) begin
            len_d   = cfg_len;
            count_d = cfg_count;
            acc_d   = '0;
            samp_d  = '0;
            neur_d  = '0;
            sat_d   = 1'b0;
            state_d = StAccum;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StAccum: begin
        if (beat) begin
          if (samp_q == len_q - LEN_W'(1)) begin
            push   = 1'b1;
            acc_d  = '0;
            samp_d = '0;
            if (sat_res.ovf) begin
              sat_d = 1'b1;
            end
            if (neur_q == count_q - CNT_W'(1)) begin
              neur_d  = '0;
              done_d  = 1'b1;
              state_d = StIdle;
            end else begin
              neur_d = neur_q + CNT_W'(1);
            end
          end else begin
            acc_d  = sum;
            samp_d = samp_q + LEN_W'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= StIdle;
      len_q   <= '0;
      count_q <= '0;
      acc_q   <= '0;
      samp_q  <= '0;
      neur_q  <= '0;
      sat_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      count_q <= count_d;
      acc_q   <= acc_d;
      samp_q  <= samp_d;
      neur_q  <= neur_d;
      sat_q   <= sat_d;
      done_q  <= done_d;
    end
  end

  psum_fifo #(
    .W     (W),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .push      (push),
    .push_data (sat_res.val[W-1:0]),
    .pop       (out_ready),
    .pop_data  (out_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign sat_flag  = sat_q;

endmodule

// File: tb/tb_psum_accumulator.sv
// Self-checking bench for psum_accumulator: directed scenarios plus randomized
// jobs compared against an integer sum-and-clamp reference model.
module tb_psum_accumulator;

  localparam int W     = 16;
  localparam int LEN_W = 8;
  localparam int CNT_W = 8;
  localparam int FD    = 4;

  logic             CLK = 1'b0;
  logic             RST_N = 1'b0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] cfg_len = '0;
  logic [CNT_W-1:0] cfg_count = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [W-1:0]     psum_in = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [W-1:0]     out_data;
  logic             busy;
  logic             done;
  logic             sat_flag;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int ready_mode = 0;
  logic [W-1:0] got[$];

  psum_accumulator #(
    .W          (W),
    .LEN_W      (LEN_W),
    .CNT_W      (CNT_W),
    .FIFO_DEPTH (FD)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .start     (start),
    .cfg_len   (cfg_len),
    .cfg_count (cfg_count),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .psum_in   (psum_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done),
    .sat_flag  (sat_flag)
  );

  always #5 CLK = ~CLK;

  // Consumer: 0 = stalled, 1 = always ready, otherwise random.
  always @(posedge CLK) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // A pop seen at the falling edge completes at the next rising edge.
  always @(negedge CLK) begin
    if (RST_N && out_valid && out_ready) got.push_back(out_data);
    if (RST_N && done) done_cnt++;
  end

  function automatic int clamp_ref(input int s);
    int hi;
    int lo;
    hi = (1 << (W - 1)) - 1;
    lo = -(1 << (W - 1));
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

  task automatic do_start(input int l, input int c);
    @(posedge CLK); #1;
    start = 1'b1;
    cfg_len = LEN_W'(l);
    cfg_count = CNT_W'(c);
    @(posedge CLK); #1;
    start = 1'b0;
  endtask

  // Presents one sample until accepted; returns #1 after the accepting edge.
  task automatic drive_beat(input logic [W-1:0] v);
    int n;
    in_valid = 1'b1;
    psum_in = v;
    n = 0;
    @(negedge CLK);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge CLK);
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL beat_accept: in_ready=%0b after %0d cycles, required 1", in_ready, n);
    end
    @(posedge CLK); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      if (got.size() >= n && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    @(negedge CLK);
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checks++;
    if ({in_ready, out_valid, busy, done, sat_flag} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl: {in_ready,out_valid,busy,done,sat}=%b required 00000",
               {in_ready, out_valid, busy, done, sat_flag});
    end
    checks++;
    if (out_data !== '0) begin
      failures++;
      $display("FAIL reset_data: out_data=%0d required 0", out_data);
    end
    @(posedge CLK); #1;
    RST_N = 1'b1;
  endtask

  task automatic test_basic();
    int exp_v[2] = '{10, 3};
    int vals[6] = '{5, -2, 7, 1, 1, 1};
    bit ok;
    ready_mode = 1;
    got.delete();
    done_cnt = 0;
    do_start(3, 2);
    foreach (vals[i]) drive_beat(W'(vals[i]));
    wait_drain(2, ok);
    checks++;
    if (!ok || got.size() != 2) begin
      failures++;
      $display("FAIL basic_count: results=%0d required 2", got.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if ($signed(got[i]) !== W'(exp_v[i])) begin
          failures++;
          $display("FAIL basic_value[%0d]: got %0d required %0d", i, $signed(got[i]), exp_v[i]);
        end
      end
    end
    checks++;
    if (done_cnt != 1 || sat_flag !== 1'b0) begin
      failures++;
      $display("FAIL basic_done_sat: done_cnt=%0d sat=%0b required 1,0", done_cnt, sat_flag);
    end
  endtask

  task automatic test_saturation();
    int vals[4] = '{30000, 30000, -30000, -30000};
    int exp_v[2] = '{32767, -32768};
    bit ok;
    ready_mode = 1;
    got.delete();
    do_start(2, 2);
    foreach (vals[i]) drive_beat(W'(vals[i]));
    wait_drain(2, ok);
    checks++;
    if (!ok || got.size() != 2) begin
      failures++;
      $display("FAIL sat_count: results=%0d required 2", got.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if ($signed(got[i]) !== W'(exp_v[i])) begin
          failures++;
          $display("FAIL sat_value[%0d]: got %0d required %0d", i, $signed(got[i]), exp_v[i]);
        end
      end
    end
    checks++;
    if (sat_flag !== 1'b1) begin
      failures++;
      $display("FAIL sat_flag: got %0b required 1", sat_flag);
    end
  endtask

  task automatic test_back_pressure();
    logic [W-1:0] vals[6];
    bit ok;
    foreach (vals[i]) vals[i] = W'($urandom);
    ready_mode = 0;
    repeat (2) @(posedge CLK);
    got.delete();
    do_start(1, 6);
    for (int i = 0; i < 4; i++) drive_beat(vals[i]);
    repeat (2) @(negedge CLK);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL bp_full: in_ready=%0b out_valid=%0b busy=%0b required 0,1,1",
               in_ready, out_valid, busy);
    end
    checks++;
    if (out_data !== vals[0] || got.size() != 0) begin
      failures++;
      $display("FAIL bp_head_hold: out_data=%0h popped=%0d required %0h,0",
               out_data, got.size(), vals[0]);
    end
    ready_mode = 1;
    for (int i = 4; i < 6; i++) drive_beat(vals[i]);
    wait_drain(6, ok);
    checks++;
    if (!ok || got.size() != 6) begin
      failures++;
      $display("FAIL bp_count: results=%0d required 6", got.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (got[i] !== vals[i]) begin
          failures++;
          $display("FAIL bp_order[%0d]: got %0h required %0h", i, got[i], vals[i]);
        end
      end
    end
  endtask

  task automatic test_gaps();
    bit ok;
    ready_mode = 1;
    got.delete();
    done_cnt = 0;
    do_start(4, 1);
    for (int i = 1; i <= 4; i++) begin
      if (i == 4) begin
        checks++;
        if (out_valid !== 1'b0) begin
          failures++;
          $display("FAIL gap_early: out_valid=%0b before last beat, required 0", out_valid);
        end
      end
      drive_beat(W'(i));
      if (i < 4) begin
        @(posedge CLK); #1;
      end
    end
    checks++;
    if (out_valid !== 1'b1 || $signed(out_data) !== 16'sd10) begin
      failures++;
      $display("FAIL gap_latency: out_valid=%0b out_data=%0d required 1,10",
               out_valid, $signed(out_data));
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL gap_done: done=%0b busy=%0b required 1,0", done, busy);
    end
    wait_drain(1, ok);
    checks++;
    if (!ok || got.size() != 1 || done_cnt != 1) begin
      failures++;
      $display("FAIL gap_final: results=%0d done_cnt=%0d required 1,1", got.size(), done_cnt);
    end
  endtask

  task automatic test_zero_and_busy_start();
    bit ok;
    ready_mode = 1;
    got.delete();
    done_cnt = 0;
    do_start(0, 3);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL zero_done: done=%0b busy=%0b required 1,0", done, busy);
    end
    repeat (3) @(negedge CLK);
    checks++;
    if (done_cnt != 1 || got.size() != 0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL zero_quiet: done_cnt=%0d results=%0d out_valid=%0b required 1,0,0",
               done_cnt, got.size(), out_valid);
    end
    done_cnt = 0;
    do_start(2, 1);
    drive_beat(W'(4));
    do_start(1, 5);
    drive_beat(W'(6));
    wait_drain(1, ok);
    repeat (4) @(negedge CLK);
    checks++;
    if (!ok || got.size() != 1 || $signed(got[0]) !== 16'sd10) begin
      failures++;
      $display("FAIL busy_start: results=%0d first=%0d required 1 result of 10",
               got.size(), (got.size() > 0) ? $signed(got[0]) : 0);
    end
    checks++;
    if (done_cnt != 1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL busy_start_done: done_cnt=%0d busy=%0b required 1,0", done_cnt, busy);
    end
  endtask

  task automatic test_mid_reset();
    bit ok;
    ready_mode = 0;
    repeat (2) @(posedge CLK);
    do_start(3, 2);
    for (int i = 1; i <= 5; i++) drive_beat(W'(i));
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL mid_queued: out_valid=%0b required 1", out_valid);
    end
    RST_N = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checks++;
    if ({in_ready, out_valid, busy, done, sat_flag} !== 5'b0 || out_data !== '0) begin
      failures++;
      $display("FAIL mid_reset: ctrl=%b out_data=%0d required 00000,0",
               {in_ready, out_valid, busy, done, sat_flag}, out_data);
    end
    @(posedge CLK); #1;
    RST_N = 1'b1;
    ready_mode = 1;
    got.delete();
    do_start(2, 1);
    drive_beat(W'(7));
    drive_beat(W'(8));
    wait_drain(1, ok);
    repeat (3) @(negedge CLK);
    checks++;
    if (!ok || got.size() != 1 || $signed(got[0]) !== 16'sd15) begin
      failures++;
      $display("FAIL mid_recover: results=%0d first=%0d required 1 result of 15",
               got.size(), (got.size() > 0) ? $signed(got[0]) : 0);
    end
  endtask

  task automatic test_random();
    int exp_q[$];
    bit exp_sat;
    bit ok;
    int l;
    int c;
    int s;
    logic [W-1:0] v;
    for (int j = 0; j < 8; j++) begin
      ready_mode = 2;
      got.delete();
      exp_q.delete();
      done_cnt = 0;
      exp_sat = 1'b0;
      l = $urandom_range(1, 5);
      c = $urandom_range(1, 6);
      do_start(l, c);
      for (int n = 0; n < c; n++) begin
        s = 0;
        for (int k = 0; k < l; k++) begin
          v = (j % 2 == 0) ? W'($urandom_range(0, 400) - 200) : W'($urandom);
          if ($urandom_range(0, 2) == 0) begin
            @(posedge CLK); #1;
          end
          drive_beat(v);
          s += int'($signed(v));
        end
        exp_q.push_back(clamp_ref(s));
        if (clamp_ref(s) != s) exp_sat = 1'b1;
      end
      wait_drain(c, ok);
      checks++;
      if (!ok || got.size() != c) begin
        failures++;
        $display("FAIL rand_count job %0d: results=%0d required %0d", j, got.size(), c);
      end else begin
        for (int i = 0; i < c; i++) begin
          checks++;
          if ($signed(got[i]) !== W'(exp_q[i])) begin
            failures++;
            $display("FAIL rand_value job %0d[%0d]: got %0d required %0d",
                     j, i, $signed(got[i]), exp_q[i]);
          end
        end
      end
      checks++;
      if (sat_flag !== exp_sat || done_cnt != 1) begin
        failures++;
        $display("FAIL rand_flags job %0d: sat=%0b done_cnt=%0d required %0b,1",
                 j, sat_flag, done_cnt, exp_sat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_back_pressure();
    test_gaps();
    test_zero_and_busy_start();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
